// File: rtl/at_script_sequencer_if.sv
// at_script_sequencer_if: CMEM read port, UART TX handshake and response
// classifier/timer signals shared between the AT script sequencer and its peers.
interface at_script_sequencer_if #(
    parameter int unsigned AW = 7
);
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          rsp_valid;
    logic [2:0]    rsp_code;
    logic [7:0]    msg_no;
    logic          ten;
    logic          tout;

    modport master (
        output rom_addr, tx_valid, tx_data, ten,
        input  rom_data, tx_ready, rsp_valid, rsp_code, msg_no, tout
    );

    modport slave (
        input  rom_addr, tx_valid, tx_data, ten,
        output rom_data, tx_ready, rsp_valid, rsp_code, msg_no, tout
    );
endinterface

// File: rtl/at_script_sequencer.sv
// at_script_sequencer: plays a descriptor table of AT commands from CMEM to the
// UART, waits for each step's response class with retry, then serves new-message
// indications by sending the read prefix, the decimal index and CR.
// Optional: define AT_RETRY_LIMIT_EN to enter ERR after MAX_RETRY retries;
// without it retries are unlimited and err stays 0.
module at_script_sequencer #(
    parameter int unsigned NSTEPS    = 3,
    parameter int unsigned AW        = 7,
    parameter logic [(NSTEPS+1)*AW-1:0] STEP_BASE = {7'd44, 7'd34, 7'd22, 7'd0},
    parameter logic [(NSTEPS+1)*6-1:0]  STEP_LEN  = {6'd8, 6'd10, 6'd12, 6'd22},
    parameter logic [(NSTEPS+1)*3-1:0]  STEP_RSP  = {3'd1, 3'd1, 3'd1, 3'd2},
    parameter int unsigned MAX_RETRY = 3,
    parameter logic [2:0]  CODE_ERR  = 3'd3,
    parameter logic [2:0]  CODE_NEW  = 3'd4,
    localparam int unsigned SW = $clog2(NSTEPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    at_script_sequencer_if.master bus,
    output logic                 busy,
    output logic                 init_done,
    output logic                 err,
    output logic                 ovr,
    output logic [SW-1:0]        step_idx
);

    localparam int unsigned RW        = $clog2(MAX_RETRY + 1);
    localparam logic [SW-1:0] PREFIX    = SW'(NSTEPS);
    localparam logic [SW-1:0] LAST_INIT = SW'(NSTEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_WAIT_RSP, S_ERR, S_READY, S_RD_IDX, S_RD_CR
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [5:0]    off_q, off_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          phase_q, phase_d;
    logic [1:0]    dig_q, dig_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_no_q, pend_no_d;
    logic [7:0]    cur_no_q, cur_no_d;
    logic          ovr_q, ovr_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          ten_q, ten_d;
    logic          busy_q, busy_d;
    logic          init_done_q, init_done_d;
    logic          err_q, err_d;
    logic          fail, restart;
    logic [1:0]    first_dig;
    logic [7:0]    dig_char;

    function automatic logic [AW-1:0] base_of(input logic [SW-1:0] s);
        return STEP_BASE[int'(s)*AW +: AW];
    endfunction

    function automatic logic [5:0] len_of(input logic [SW-1:0] s);
        return STEP_LEN[int'(s)*6 +: 6];
    endfunction

    function automatic logic [2:0] rsp_of(input logic [SW-1:0] s);
        return STEP_RSP[int'(s)*3 +: 3];
    endfunction

    // Decimal digit selection for the latched message index (no leading zeros)
    always_comb begin
        first_dig = (cur_no_q >= 8'd100) ? 2'd0 : ((cur_no_q >= 8'd10) ? 2'd1 : 2'd2);
        case (dig_q)
            2'd0:    dig_char = 8'h30 + (cur_no_q / 8'd100);
            2'd1:    dig_char = 8'h30 + ((cur_no_q / 8'd10) % 8'd10);
            default: dig_char = 8'h30 + (cur_no_q % 8'd10);
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        off_d      = off_q;
        retry_d    = retry_q;
        phase_d    = phase_q;
        dig_d      = dig_q;
        pend_d     = pend_q;
        pend_no_d  = pend_no_q;
        cur_no_d   = cur_no_q;
        ovr_d      = ovr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        fail       = 1'b0;
        restart    = 1'b0;

        case (state_q)
            S_IDLE, S_ERR: restart = start;
            S_FETCH: begin
                // Phase 0 lets the synchronous ROM capture rom_addr
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    tx_data_d  = bus.rom_data;
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (off_q + 6'd1 == len_of(step_q)) begin
                        off_d = 6'd0;
                        if (step_q == PREFIX) begin
                            dig_d   = first_dig;
                            state_d = S_RD_IDX;
                        end else begin
                            state_d = S_WAIT_RSP;
                        end
                    end else begin
                        off_d   = off_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WAIT_RSP: begin
                // A response strobe takes priority over a simultaneous timeout
                if (bus.rsp_valid) begin
                    if (bus.rsp_code != CODE_NEW && bus.rsp_code == rsp_of(step_q)) begin
                        retry_d = '0;
                        if (step_q >= LAST_INIT) begin
                            state_d = S_READY;
                        end else begin
                            step_d  = step_q + SW'(1);
                            state_d = S_FETCH;
                        end
                    end else if (bus.rsp_code == CODE_ERR) begin
                        fail = 1'b1;
                    end
                end else if (bus.tout) begin
                    fail = 1'b1;
                end
            end
            S_READY: begin
                if (pend_q) begin
                    cur_no_d = pend_no_q;
                    pend_d   = 1'b0;
                    step_d   = PREFIX;
                    off_d    = 6'd0;
                    state_d  = S_FETCH;
                end
            end
            S_RD_IDX: begin
                if (!tx_valid_q) begin
                    tx_data_d  = dig_char;
                    tx_valid_d = 1'b1;
                end else if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (dig_q == 2'd2) begin
                        state_d = S_RD_CR;
                    end else begin
                        dig_d = dig_q + 2'd1;
                    end
                end
            end
            S_RD_CR: begin
                if (!tx_valid_q) begin
                    tx_data_d  = 8'h0D;
                    tx_valid_d = 1'b1;
                end else if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_WAIT_RSP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Failed step: resend from offset 0, or give up once retries are spent
        if (fail) begin
            off_d   = 6'd0;
            phase_d = 1'b0;
`ifdef AT_RETRY_LIMIT_EN
            if (retry_q == RW'(MAX_RETRY)) begin
                state_d = S_ERR;
            end else begin
                retry_d = retry_q + RW'(1);
                state_d = S_FETCH;
            end
`else
            if (retry_q != RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
            end
            state_d = S_FETCH;
`endif
        end

        if (restart) begin
            state_d = S_FETCH;
            step_d  = '0;
            off_d   = 6'd0;
            retry_d = '0;
            phase_d = 1'b0;
            ovr_d   = 1'b0;
            pend_d  = 1'b0;
        end

        // New-message indications are latched in any active state; newest wins
        if (bus.rsp_valid && bus.rsp_code == CODE_NEW && state_q != S_IDLE && state_q != S_ERR) begin
            if (pend_d) begin
                ovr_d = 1'b1;
            end
            pend_d    = 1'b1;
            pend_no_d = bus.msg_no;
        end

        rom_addr_d  = base_of(step_d) + AW'(off_d);
        ten_d       = (state_d == S_WAIT_RSP);
        busy_d      = (state_d != S_IDLE) && (state_d != S_READY) && (state_d != S_ERR);
        init_done_d = (state_d == S_READY) ||
                      ((step_d == PREFIX) && (state_d != S_IDLE) && (state_d != S_ERR));
`ifdef AT_RETRY_LIMIT_EN
        err_d       = (state_d == S_ERR);
`else
        err_d       = 1'b0;
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            off_q       <= 6'd0;
            retry_q     <= '0;
            phase_q     <= 1'b0;
            dig_q       <= 2'd0;
            pend_q      <= 1'b0;
            pend_no_q   <= 8'd0;
            cur_no_q    <= 8'd0;
            ovr_q       <= 1'b0;
            rom_addr_q  <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            ten_q       <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            off_q       <= off_d;
            retry_q     <= retry_d;
            phase_q     <= phase_d;
            dig_q       <= dig_d;
            pend_q      <= pend_d;
            pend_no_q   <= pend_no_d;
            cur_no_q    <= cur_no_d;
            ovr_q       <= ovr_d;
            rom_addr_q  <= rom_addr_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            ten_q       <= ten_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.ten      = ten_q;
    assign busy         = busy_q;
    assign init_done    = init_done_q;
    assign err          = err_q;
    assign ovr          = ovr_q;
    assign step_idx     = step_q;

endmodule

// File: tb/tb_at_script_sequencer.sv
// Directed bench for at_script_sequencer: ROM model, byte capture, hand-built
// expected TX streams and status checks.
module tb_at_script_sequencer;

    localparam int unsigned AW = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, init_done, err, ovr;
    logic [1:0] step_idx;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'd0;

    at_script_sequencer_if #(.AW(AW)) bus ();

    at_script_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .init_done (init_done),
        .err       (err),
        .ovr       (ovr),
        .step_idx  (step_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [6:0] a);
        return 8'({1'b0, a} * 8'd5 + 8'h11);
    endfunction

    // Synchronous CMEM model
    always @(posedge clk) bus.rom_data <= rom_byte(bus.rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture accepted bytes and check that a stalled byte is held stable
    always @(negedge clk) begin
        if (rst_n && pv && !pr)
            chk("tx_hold", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, pd}));
        if (bus.tx_valid && bus.tx_ready)
            cap_q.push_back(bus.tx_data);
        pv = bus.tx_valid;
        pr = bus.tx_ready;
        pd = bus.tx_data;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rsp(input logic [2:0] code, input logic [7:0] msg = 8'd0);
        bus.rsp_valid = 1'b1;
        bus.rsp_code  = code;
        bus.msg_no    = msg;
        tick();
        bus.rsp_valid = 1'b0;
        bus.rsp_code  = 3'd0;
    endtask

    task automatic wait_ten();
        int n;
        n = 0;
        while (!bus.ten && n < 2000) begin
            tick();
            n++;
        end
        if (!bus.ten) chk("ten_timeout", 32'd0, 32'd1);
    endtask

    task automatic step_ok(input logic [2:0] code);
        wait_ten();
        tick(5);
        rsp(code);
    endtask

    task automatic add_rng(input int lo, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(rom_byte(7'(lo + i)));
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    endtask

    task automatic check_stream(input string tag);
        int d, n;
        d = 0;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        chk({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) d++;
        chk(tag, 32'(d), 32'd0);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic read_msg(input logic [7:0] msg, input string tag);
        rsp(3'd4, msg);
        add_rng(44, 8);
        add_str($sformatf("%0d", msg));
        exp_q.push_back(8'h0D);
        wait_ten();
        chk({tag, "_step"}, 32'(step_idx), 32'd3);
        check_stream(tag);
        tick(3);
        rsp(3'd1);
        tick();
        chk({tag, "_ready"}, 32'({busy, init_done}), 32'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.tx_ready  = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_code  = 3'd0;
        bus.msg_no    = 8'd0;
        bus.tout      = 1'b0;
        tick(3);
        chk("reset_outs", 32'({busy, init_done, err, ovr, step_idx, bus.tx_valid,
                               bus.tx_data, bus.ten, bus.rom_addr}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Init script with a 10-cycle stall in step 0
        pulse_start();
        chk("busy_run", 32'(busy), 32'd1);
        add_rng(0, 22); add_rng(22, 12); add_rng(34, 10);
        fork
            begin
                int n;
                n = 0;
                while (cap_q.size() < 8 && n < 500) begin
                    tick();
                    n++;
                end
                bus.tx_ready = 1'b0;
                tick(5);
                chk("stall_valid", 32'(bus.tx_valid), 32'd1);
                tick(5);
                bus.tx_ready = 1'b1;
            end
            begin
                step_ok(3'd2);
                step_ok(3'd1);
                wait_ten();
                tick(5);
                chk("init_done_pre", 32'(init_done), 32'd0);
                rsp(3'd1);
                chk("init_done", 32'({init_done, busy}), 32'b10);
            end
        join
        check_stream("init_stream");

        // Message reads at the decimal boundaries
        read_msg(8'd142, "rd142");
        read_msg(8'd0,   "rd0");
        read_msg(8'd255, "rd255");

        // Two indications during a read: overrun, only the newest is read next
        rsp(3'd4, 8'd5);
        tick(4);
        rsp(3'd4, 8'd9);
        chk("ovr_single", 32'(ovr), 32'd0);
        tick(3);
        rsp(3'd4, 8'd77);
        chk("ovr_set", 32'(ovr), 32'd1);
        add_rng(44, 8); add_str("5"); exp_q.push_back(8'h0D);
        wait_ten();
        check_stream("rd5");
        tick(2);
        rsp(3'd1);
        add_rng(44, 8); add_str("77"); exp_q.push_back(8'h0D);
        wait_ten();
        check_stream("rd77");
        rsp(3'd1);
        tick();
        pulse_start();
        tick(3);
        chk("start_ignored", 32'({busy, ovr, init_done}), 32'b011);

        // Asynchronous reset while a byte is offered
        do_reset();
        pulse_start();
        begin
            int n;
            n = 0;
            while (!bus.tx_valid && n < 100) begin
                tick();
                n++;
            end
            chk("send_seen", 32'(bus.tx_valid), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'({busy, init_done, err, ovr, step_idx, bus.tx_valid,
                                bus.tx_data, bus.ten, bus.rom_addr}), 32'd0);
        tick(3);
        rst_n = 1'b1;
        cap_q.delete();
        tick(20);
        chk("idle_quiet", 32'({cap_q.size() != 0, busy}), 32'd0);

        // Step 1 times out three times, then succeeds
        do_reset();
        pulse_start();
        step_ok(3'd2);
        for (int k = 0; k < 3; k++) begin
            wait_ten();
            tick(3);
            bus.tout = 1'b1;
            tick();
            bus.tout = 1'b0;
            if (k == 0) chk("ten_drop", 32'(bus.ten), 32'd0);
        end
        step_ok(3'd1);
        step_ok(3'd1);
        tick();
        add_rng(0, 22);
        for (int k = 0; k < 4; k++) add_rng(22, 12);
        add_rng(34, 10);
        check_stream("retry_stream");
        chk("retry_done", 32'({init_done, err}), 32'b10);

        // Step 0 answered with ERROR four times
        do_reset();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_ten();
            tick(2);
            rsp(3'd3);
        end
`ifdef AT_RETRY_LIMIT_EN
        tick();
        chk("err_state", 32'({err, bus.tx_valid, busy}), 32'b100);
        for (int k = 0; k < 4; k++) add_rng(0, 22);
        check_stream("err_stream");
        pulse_start();
        begin
            int n;
            n = 0;
            while (cap_q.size() == 0 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("replay_first", 32'((cap_q.size() != 0) ? cap_q[0] : 8'h00), 32'(rom_byte(7'd0)));
        chk("replay_err", 32'(err), 32'd0);
`else
        chk("no_err", 32'(err), 32'd0);
        wait_ten();
        for (int k = 0; k < 5; k++) add_rng(0, 22);
        check_stream("err_stream");
        chk("still_busy", 32'({busy, err}), 32'b10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
